// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/sequencing stage in front of a 4-bit ALU with a 4x4-bit register file
//   clk, rst                         clock, async active-high reset
//   in_valid/in_ready, in_kind, in_op, in_rd, in_rs1, in_rs2, in_imm   instruction stream
//   alu_a, alu_b, alu_ctl / alu_ans, alu_cout                          ALU drive / ALU result
//   out_valid/out_ready, out_data, out_carry                           result stream
//   carry_flag                        sticky carry of last committed ALU op
//   dbg_addr / dbg_data               combinational register file read
module alu_issue_ctrl #(
   parameter int EXEC_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_kind,
   input  logic [2:0] in_op,
   input  logic [1:0] in_rd,
   input  logic [1:0] in_rs1,
   input  logic [1:0] in_rs2,
   input  logic [3:0] in_imm,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [2:0] alu_ctl,
   input  logic [3:0] alu_ans,
   input  logic       alu_cout,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_data,
   output logic       out_carry,
   output logic       carry_flag,
   input  logic [1:0] dbg_addr,
   output logic [3:0] dbg_data
);
   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
   localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);
   state_t     state_q, state_d;
   logic [3:0] rf_q [4];
   logic [3:0] rf_d [4];
   logic       carry_q, carry_d;
   logic [3:0] res_q, res_d;
   logic       res_c_q, res_c_d;
   logic       kind_q, kind_d;
   logic [2:0] op_q, op_d;
   logic [1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
   logic [3:0] cnt_q, cnt_d;
   logic       in_exec;
   assign in_ready   = state_q == IDLE && !rst;
   assign in_exec    = state_q == EXEC;
   assign alu_a      = in_exec ? rf_q[rs1_q] : '0;
   assign alu_b      = in_exec ? rf_q[rs2_q] : '0;
   assign alu_ctl    = in_exec ? op_q : '0;
   assign out_valid  = state_q == WB;
   assign out_data   = res_q;
   assign out_carry  = res_c_q;
   assign carry_flag = carry_q;
   assign dbg_data   = rf_q[dbg_addr];
   always_comb begin
      state_d = state_q;
      rf_d    = rf_q;
      carry_d = carry_q;
      res_d   = res_q;
      res_c_d = res_c_q;
      kind_d  = kind_q;
      op_d    = op_q;
      rd_d    = rd_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (in_valid && in_ready) begin
            kind_d  = in_kind;
            op_d    = in_op;
            rd_d    = in_rd;
            rs1_d   = in_rs1;
            rs2_d   = in_rs2;
            // LDI skips the ALU: the immediate goes straight into the result register
            res_d   = in_kind ? in_imm : res_q;
            res_c_d = in_kind ? 1'b0 : res_c_q;
            cnt_d   = in_kind ? cnt_q : CNT_INIT;
            state_d = in_kind ? WB : EXEC;
         end
         EXEC: if (cnt_q == '0) begin
            res_d   = alu_ans;
            res_c_d = alu_cout;
            state_d = WB;
         end else begin
            cnt_d = cnt_q - 4'd1;
         end
         WB: if (out_ready) begin
            rf_d[rd_q] = res_q;
            carry_d    = kind_q ? carry_q : res_c_q;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rf_q    <= '{default: '0};
         carry_q <= 1'b0;
         res_q   <= '0;
         res_c_q <= 1'b0;
         kind_q  <= 1'b0;
         op_q    <= '0;
         rd_q    <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rf_q    <= rf_d;
         carry_q <= carry_d;
         res_q   <= res_d;
         res_c_q <= res_c_d;
         kind_q  <= kind_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequencing stage directly upstream of the 4-bit ALU.
- Accepts instructions on a valid/ready stream and holds a 4 x 4-bit register file.
- Drives the ALU operand/opcode inputs from the register file, waits a programmable settle time, then captures the ALU result and carry.
- Presents the result on a valid/ready output stream and writes it back to the register file on handshake.

Parameters:
- EXEC_CYCLES, 1, number of cycles ALU inputs are held stable before result capture (legal range 1..15).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  instruction valid
- in_ready  out  1  instruction accepted when in_valid && in_ready
- in_kind  in  1  0 = ALU op, 1 = load immediate (LDI)
- in_op  in  3  ALU opcode passed to ALU_ctl (ALU op only)
- in_rd  in  2  destination register index
- in_rs1  in  2  source register for ALU operand A
- in_rs2  in  2  source register for ALU operand B
- in_imm  in  4  immediate value (LDI only)
- alu_a  out  4  to ALU A
- alu_b  out  4  to ALU B
- alu_ctl  out  3  to ALU ALU_ctl
- alu_ans  in  4  from ALU ans
- alu_cout  in  1  from ALU cout
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  4  result value
- out_carry  out  1  result carry (0 for LDI)
- carry_flag  out  1  sticky carry of last committed ALU op
- dbg_addr  in  2  register file debug read index
- dbg_data  out  4  combinational read of R[dbg_addr]

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high; ports named clk and rst.
- Reset values:
  - state IDLE; R0..R3 = 0; carry_flag = 0.
  - Result register = 0; out_valid = 0; alu_a/alu_b/alu_ctl = 0.
  - Latched instruction fields = 0; settle counter = 0.
  - in_ready = 0 while rst is high.
- States: IDLE, EXEC, WB.
- IDLE:
  - in_ready = 1. On accept, latch kind/op/rd/rs1/rs2/imm.
  - ALU op -> EXEC with counter = EXEC_CYCLES-1.
  - LDI -> WB with result = imm, result carry = 0.
- EXEC:
  - alu_a = R[rs1], alu_b = R[rs2], alu_ctl = latched op, all held constant.
  - Counter decrements each cycle.
  - In the cycle the counter is 0: capture alu_ans/alu_cout into the result register, then go to WB.
  - rs1 == rs2 is legal.
- Outside EXEC: alu_a, alu_b and alu_ctl drive 0.
- WB:
  - out_valid = 1; out_data/out_carry come from the result register and stay stable until handshake.
  - On out_valid && out_ready:
    - R[rd] <= result.
    - carry_flag <= result carry for ALU ops; carry_flag is unchanged for LDI.
    - Go to IDLE.
- in_ready = 0 in EXEC and WB. Instructions are strictly serialized, so there is no hazard logic: a source read in EXEC always sees every earlier committed write.
- Latency, ALU op accepted in cycle 0:
  - ALU inputs are valid in cycles 1..EXEC_CYCLES.
  - out_valid is first high in cycle EXEC_CYCLES+1.
- Latency, LDI accepted in cycle 0: out_valid is first high in cycle 1.
- Throughput: after the output handshake in cycle k, in_ready = 1 in cycle k+1. Peak rate is one ALU op per EXEC_CYCLES+2 cycles.
- Backpressure: out_ready low holds WB indefinitely; no register write occurs until handshake.
- rd equal to rs1/rs2 is legal; the write happens only at commit.
- Reset mid-operation (EXEC or WB): abort immediately, no write-back, all state returns to reset values.
- dbg_data reflects a register write starting the cycle after the commit edge.

Test Plan:
- LDI R1=7, LDI R2=9, ALU op 000 rd=R3, rs1=R1, rs2=R2 -> out_data=0, out_carry=1; R3=0 and carry_flag=1 after handshake.
- LDI R0=3, LDI R1=5, op 001 rd=R2 (R0-R1) -> out_data=14, out_carry=0; carry_flag cleared to 0.
- LDI R0=5, op 101 rd=R0, rs1=R0 -> out_data=2, out_carry=1, R0=2. Then op 110 rd=R0, rs1=R0 -> out_data=4, out_carry=0.
- EXEC_CYCLES=3, op 010 on R1=12, R2=10 -> alu_a/alu_b/alu_ctl stable for exactly 3 cycles; out_valid first high at cycle 4; out_data=8.
- Hold out_ready=0 for 5 cycles in WB -> out_valid and out_data stable, in_ready=0, dbg_data of rd unchanged. Then raise out_ready -> commit; in_ready=1 the next cycle.
- Assert rst during EXEC of op 000 into R3 (R3 previously 6) -> out_valid never rises, R3=0 (reset), carry_flag=0, in_ready=1 after rst deasserts.
